vdp_wb_bridge: RTL
==================

VDP_WB_BRIDGE -- requirements
Module: vdp_wb_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, write-FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter RD_TIMEOUT, default 255, max cycles waiting for host_read_valid, 1..255.
REQ-003 SHALL have port wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave controls.
REQ-006 SHALL have ports wbs_sel_i  input  4, wbs_adr_i  input  32, wbs_dat_i  input  32  Wishbone select, address, write data.
REQ-007 SHALL have ports wbs_ack_o  output  1, wbs_dat_o  output  32  Wishbone acknowledge and read data.
REQ-008 SHALL have ports host_addr  output  6, host_write_data  output  16, host_write_en  output  1  VDP register write port.
REQ-009 SHALL have port host_ready  input  1  VDP accepts a write in any cycle with host_write_en and host_ready both high.
REQ-010 SHALL have ports host_read_en  output  1, host_read_data  input  16, host_read_valid  input  1  VDP register read port.
REQ-011 SHALL have port rd_timeout_err  output  1  sticky flag, set on read timeout.

Function
REQ-012 Access starts when wbs_cyc_i and wbs_stb_i are high while the FSM is in IDLE; inside window iff wbs_adr_i[31:24]==8'h30.
REQ-013 Out-of-window access SHALL be acked after 1 cycle; reads return 32'h0; writes are dropped.
REQ-014 FSM states: IDLE, WR_PUSH, RD_DRAIN, RD_REQ, RD_WAIT, ACK.
REQ-015 In-window write: IDLE->WR_PUSH; push {wbs_adr_i[7:2], wbs_dat_i[15:0]} in the first WR_PUSH cycle with FIFO not full; go ACK; stall in WR_PUSH while full.
REQ-016 Write with wbs_sel_i[1:0]==2'b00 SHALL be acked without a push.
REQ-017 In-window read: IDLE->RD_DRAIN; wait until FIFO is empty and no write is pending; ->RD_REQ.
REQ-018 RD_REQ: drive host_read_en high for exactly 1 cycle with host_addr=wbs_adr_i[7:2]; ->RD_WAIT.
REQ-019 RD_WAIT: on host_read_valid, latch wbs_dat_o={16'h0,host_read_data}; ->ACK.
REQ-020 RD_WAIT: after RD_TIMEOUT cycles without host_read_valid, set wbs_dat_o=32'hFFFF_FFFF and set rd_timeout_err; ->ACK.
REQ-021 ACK: wbs_ack_o high for exactly 1 cycle; ->IDLE; ack SHALL never be high 2 consecutive cycles.
REQ-022 FIFO drain runs independently of the FSM: host_write_en = FIFO not empty; host_addr/host_write_data = head entry; pop when host_ready.
REQ-023 While host_read_en is high, host_addr SHALL carry the read address, and host_write_en SHALL be low.
REQ-024 Simultaneous push and pop in one cycle SHALL keep the occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 Writes SHALL reach the VDP in Wishbone issue order; a read SHALL observe all earlier writes.
REQ-026 wbs_cyc_i dropping mid-transaction SHALL return the FSM to IDLE next cycle without ack; already-pushed data is retained.
REQ-027 rd_timeout_err SHALL clear only on reset or on an in-window write to word offset 6'h3F with wbs_dat_i[0]=1; such a write is not pushed.
REQ-028 Write ack latency SHALL be 2 cycles from stb when not full; read latency is drain + 2 + VDP response time.

Reset
REQ-029 While wb_rst_i is high, asynchronously: FSM=IDLE, FIFO empty, wbs_ack_o=0, wbs_dat_o=0, host_write_en=0, host_read_en=0, host_addr=0, host_write_data=0, rd_timeout_err=0.
REQ-030 Reset mid-transaction SHALL abort the transaction and discard FIFO contents; no ack SHALL be issued for the aborted cycle.
REQ-031 First access SHALL be accepted in the first rising edge after wb_rst_i deasserts.

Verification
REQ-032 Write 0x3000_0008 data 0x1234, host_ready=1 -> ack at cycle 2; host_addr=2, host_write_data=0x1234, pulse 1 cycle.
REQ-033 host_ready=0, 5 back-to-back writes, depth 4 -> 4 acked, 5th stalls until host_ready=1, then 5 writes reach the VDP in order.
REQ-034 3 queued writes then read 0x3000_0010, host_read_valid 3 cycles after host_read_en with 0xBEEF -> read_en only after 3rd pop; wbs_dat_o=0x0000_BEEF.
REQ-035 Read with host_read_valid never asserted, RD_TIMEOUT=8 -> ack after 8 RD_WAIT cycles, data 0xFFFF_FFFF, rd_timeout_err=1; write 0x3000_00FC data 1 clears it.
REQ-036 Access 0x2000_0000 -> ack in 1 cycle, read data 0, no host activity.
REQ-037 Assert wb_rst_i during RD_WAIT with 2 FIFO entries -> no ack; outputs reset immediately; FIFO empty after release.

Source files
------------

// File: rtl/vdp_wb_bridge.sv
// Wishbone classic slave bridging a 0x30xx_xxxx window onto the VDP register port.
// Writes are posted through a small FIFO; reads wait for the FIFO to drain first.
module vdp_wb_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [5:0]  host_addr,
    output logic [15:0] host_write_data,
    output logic        host_write_en,
    input  logic        host_ready,
    output logic        host_read_en,
    input  logic [15:0] host_read_data,
    input  logic        host_read_valid,
    output logic        rd_timeout_err
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WR_PUSH,
        RD_DRAIN,
        RD_REQ,
        RD_WAIT,
        ACK
    } state_t;

    state_t        r_state;
    logic [21:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_ack;
    logic [31:0]   r_dat;
    logic          r_rd_en;
    logic [5:0]    r_rd_addr;
    logic [7:0]    r_tmr;
    logic          r_err;

    logic          w_empty;
    logic          w_full;
    logic          w_in_win;
    logic          w_clr;
    logic          w_skip;
    logic          w_push;
    logic          w_pop;
    logic [21:0]   w_head;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_in_win = (wbs_adr_i[31:24] == 8'h30);
    assign w_clr    = (wbs_adr_i[7:2] == 6'h3F) && wbs_dat_i[0];
    assign w_skip   = w_clr || (wbs_sel_i[1:0] == 2'b00);
    assign w_push   = (r_state == WR_PUSH) && wbs_cyc_i && !w_full && !w_skip;
    assign w_head   = r_mem[r_rd_ptr];

    // Head is gated to zero when empty so stale storage never leaks out.
    assign host_write_en   = !w_empty && !r_rd_en;
    assign w_pop           = host_write_en && host_ready;
    assign host_write_data = w_empty ? 16'h0 : w_head[15:0];
    assign host_addr       = r_rd_en ? r_rd_addr
                           : (w_empty ? 6'h0 : w_head[21:16]);
    assign host_read_en    = r_rd_en;
    assign wbs_ack_o       = r_ack;
    assign wbs_dat_o       = r_dat;
    assign rd_timeout_err  = r_err;

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wbs_adr_i[7:2], wbs_dat_i[15:0]};
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_tmr     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_ack   <= 1'b0;
            r_rd_en <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        if (!w_in_win) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                            r_dat   <= '0;
                        end else if (wbs_we_i) begin
                            r_state <= WR_PUSH;
                        end else begin
                            r_state <= RD_DRAIN;
                        end
                    end
                end
                WR_PUSH: begin
                    if (!wbs_cyc_i) begin
                        r_state <= IDLE;
                    end else if (w_skip) begin
                        if (w_clr) begin
                            r_err <= 1'b0;
                        end
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end else if (!w_full) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end
                end
                RD_DRAIN: begin
                    if (!wbs_cyc_i) begin
                        r_state <= IDLE;
                    end else if (w_empty) begin
                        r_state   <= RD_REQ;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= wbs_adr_i[7:2];
                        r_tmr     <= '0;
                    end
                end
                RD_REQ: begin
                    r_state <= wbs_cyc_i ? RD_WAIT : IDLE;
                end
                RD_WAIT: begin
                    if (!wbs_cyc_i) begin
                        r_state <= IDLE;
                    end else if (host_read_valid) begin
                        r_dat   <= {16'h0, host_read_data};
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end else if (r_tmr == 8'(RD_TIMEOUT - 1)) begin
                        r_dat   <= 32'hFFFF_FFFF;
                        r_err   <= 1'b1;
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + 8'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
